// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes from the sensor FIFO read port
// and sends each one as an 8N1 UART frame on tx.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  input  logic       fifo_valid,
  input  logic       fifo_underflow,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       byte_done,
  output logic       err_underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tick;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      tx            <= 1'b1;
      fifo_rd_en    <= 1'b0;
      busy          <= 1'b0;
      byte_done     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      byte_done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= S_READ;
          end
        end
        S_READ: state <= S_WAIT;
        // valid takes priority over a simultaneous underflow
        S_WAIT: begin
          if (fifo_valid) begin
            shift <= fifo_dout;
            tx    <= 1'b0;
            cnt   <= '0;
            state <= S_START;
          end else if (fifo_underflow) begin
            err_underflow <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_START: begin
          if (tick) begin
            cnt     <= '0;
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt       <= '0;
            byte_done <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO read-port model, UART frame
// monitor against an expected-byte queue, scenario tasks.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty;
  logic       fifo_valid = 1'b0;
  logic       fifo_underflow = 1'b0;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       byte_done;
  logic       err_underflow;

  int tests = 0;
  int fails = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_valid    (fifo_valid),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .tx            (tx),
    .busy          (busy),
    .byte_done     (byte_done),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // FIFO read-port model
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  bit         uf_mode = 1'b0;
  bit         fake_avail = 1'b0;
  logic [7:0] exp_q [$];

  assign fifo_empty = (wr_ptr == rd_ptr) && !fake_avail;

  always @(posedge clk) begin
    fifo_valid     <= 1'b0;
    fifo_underflow <= 1'b0;
    if (fifo_rd_en) begin
      if (uf_mode || wr_ptr == rd_ptr) begin
        fifo_underflow <= 1'b1;
      end else begin
        fifo_dout  <= mem[rd_ptr];
        fifo_valid <= 1'b1;
        rd_ptr     <= rd_ptr + 8'd1;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(b);
  endtask

  // read strobe must never be high two cycles running
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      tests++;
      if (prev_rd) begin
        fails++;
        $display("FAIL rd_en_consecutive: rd_en high 2 cycles, required 1");
      end
    end
    prev_rd = fifo_rd_en;
  end

  // UART frame monitor / scoreboard
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  bit         mon_err = 1'b0;
  logic [9:0] mon_frame = '0;
  logic [7:0] mon_rx = '0;
  logic [7:0] mon_exp = '0;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_unexpected: tx start bit, required no frame");
        end else begin
          mon_active = 1'b1;
          mon_cnt = 0;
          mon_err = 1'b0;
          mon_exp = exp_q[0];
          mon_frame = {1'b1, mon_exp, 1'b0};
          mon_rx = '0;
        end
      end
      if (mon_active) begin
        if (mon_cnt == FRAME) begin
          void'(exp_q.pop_front());
          tests++;
          if (mon_err || byte_done !== 1'b1 || mon_rx !== mon_exp) begin
            fails++;
            $display("FAIL frame: rx=%02h done=%b wave_err=%b, required rx=%02h done=1 wave_err=0",
                     mon_rx, byte_done, mon_err, mon_exp);
          end
          mon_active = 1'b0;
        end else begin
          if (tx !== mon_frame[mon_cnt / CPB]) mon_err = 1'b1;
          if (byte_done !== 1'b0) mon_err = 1'b1;
          if (mon_cnt % CPB == CPB / 2 && mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8)
            mon_rx[mon_cnt / CPB - 1] = tx;
          mon_cnt++;
        end
      end
    end
  end

  task automatic observe(input int n, output int rd, output int done,
                         output int t_rd, output int t_fall,
                         output int t_done, output bit tx_low);
    logic ptx;
    rd = 0; done = 0; t_rd = -1; t_fall = -1; t_done = -1; tx_low = 0;
    ptx = tx;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        rd++;
        if (t_rd < 0) t_rd = i;
      end
      if (byte_done) begin
        done++;
        if (t_done < 0) t_done = i;
      end
      if (tx === 1'b0) tx_low = 1;
      if (tx === 1'b0 && ptx === 1'b1 && t_fall < 0) t_fall = i;
      ptx = tx;
    end
  endtask

  task automatic wait_fall(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      if (tx === 1'b0) ok = 1;
    end
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      if (byte_done === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset;
    logic [4:0] v;
    push_byte(8'hAA);
    enable = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v = {tx, fifo_rd_en, busy, byte_done, err_underflow};
      tests++;
      if (v !== 5'b10000) begin
        fails++;
        $display("FAIL reset_cycle%0d: {tx,rd,busy,done,err}=%b, required 10000", i, v);
      end
    end
    #1 enable = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_byte;
    int rd, done, t_rd, t_fall, t_done;
    bit low;
    @(negedge clk);
    #1 enable = 1'b1;
    observe(60, rd, done, t_rd, t_fall, t_done, low);
    tests++;
    if (rd !== 1 || done !== 1) begin
      fails++;
      $display("FAIL single_counts: rd=%0d done=%0d, required 1 1", rd, done);
    end
    tests++;
    if (t_fall - t_rd !== 2) begin
      fails++;
      $display("FAIL single_latency: rd->fall=%0d, required 2", t_fall - t_rd);
    end
    tests++;
    if (t_done - t_fall !== FRAME) begin
      fails++;
      $display("FAIL single_length: fall->done=%0d, required %0d", t_done - t_fall, FRAME);
    end
    tests++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_end: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    #1 enable = 1'b0;
  endtask

  task automatic test_back_to_back;
    int rd, done, t_rd, t_fall, t_done;
    bit low, ok;
    logic rd1;
    logic [2:0] gap;
    push_byte(8'hAA);
    push_byte(8'hBB);
    @(negedge clk);
    #1 enable = 1'b1;
    wait_done(80, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL b2b_first_done: timeout, required byte_done");
    end
    @(negedge clk);
    rd1 = fifo_rd_en;
    gap[2] = tx;
    @(negedge clk);
    gap[1] = tx;
    @(negedge clk);
    gap[0] = tx;
    tests++;
    if (rd1 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_rd_after_done: rd_en=%b, required 1", rd1);
    end
    tests++;
    if (gap !== 3'b110) begin
      fails++;
      $display("FAIL b2b_gap: tx after done=%b, required 110", gap);
    end
    observe(60, rd, done, t_rd, t_fall, t_done, low);
    tests++;
    if (done !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL b2b_second: done=%0d pending=%0d, required 1 0", done, exp_q.size());
    end
    #1 enable = 1'b0;
  endtask

  task automatic test_underflow;
    int rd, done, t_rd, t_fall, t_done;
    bit low;
    uf_mode = 1'b1;
    fake_avail = 1'b1;
    @(negedge clk);
    #1 enable = 1'b1;
    observe(20, rd, done, t_rd, t_fall, t_done, low);
    #1 enable = 1'b0;
    fake_avail = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (err_underflow !== 1'b1 || low || rd < 1) begin
      fails++;
      $display("FAIL underflow_flag: err=%b tx_went_low=%b reads=%0d, required 1 0 >=1",
               err_underflow, low, rd);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL underflow_idle: busy=%b, required 0", busy);
    end
    uf_mode = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (err_underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_sticky: err=%b, required 1", err_underflow);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (err_underflow !== 1'b0) begin
      fails++;
      $display("FAIL underflow_clear: err=%b, required 0", err_underflow);
    end
  endtask

  task automatic test_enable_drop;
    int rd, done, t_rd, t_fall, t_done;
    bit low, ok;
    push_byte(8'hAA);
    push_byte(8'hBB);
    push_byte(8'hC3);
    @(negedge clk);
    #1 enable = 1'b1;
    wait_fall(20, ok);
    repeat (4 * CPB) @(negedge clk);
    #1 enable = 1'b0;
    wait_done(FRAME, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drop_done: timeout, required byte_done");
    end
    observe(50, rd, done, t_rd, t_fall, t_done, low);
    tests++;
    if (rd !== 0 || busy !== 1'b0 || exp_q.size() !== 2) begin
      fails++;
      $display("FAIL drop_hold: rd=%0d busy=%b pending=%0d, required 0 0 2",
               rd, busy, exp_q.size());
    end
    #1 enable = 1'b1;
    observe(100, rd, done, t_rd, t_fall, t_done, low);
    tests++;
    if (done !== 2 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL drop_resume: done=%0d pending=%0d, required 2 0", done, exp_q.size());
    end
    #1 enable = 1'b0;
  endtask

  task automatic test_reset_mid;
    int rd, done, t_rd, t_fall, t_done;
    bit low, ok;
    logic [1:0] v;
    push_byte(8'h5D);
    push_byte(8'hE7);
    @(negedge clk);
    #1 enable = 1'b1;
    wait_fall(20, ok);
    repeat (6 * CPB) @(negedge clk);
    #1 reset = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    v = {tx, busy};
    tests++;
    if (v !== 2'b10) begin
      fails++;
      $display("FAIL midreset_outputs: {tx,busy}=%b, required 10", v);
    end
    #1 reset = 1'b0;
    observe(60, rd, done, t_rd, t_fall, t_done, low);
    tests++;
    if (rd !== 1 || done !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL midreset_next: rd=%0d done=%0d pending=%0d, required 1 1 0",
               rd, done, exp_q.size());
    end
    #1 enable = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_underflow;
    test_enable_drop;
    test_reset_mid;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
